neuron_mac_layer: RTL and testbench

//  Dense-layer multiply-accumulate stage. Streams one input element per beat, multiplies it
//  by one weight per neuron, and accumulates onto a per-neuron bias.

---
 rtl/mac_pkg.sv | 41 ++++
 rtl/neuron_mac_layer_if.sv | 26 ++
 rtl/mac_lane.sv | 59 +++++
 rtl/neuron_mac_layer.sv | 102 ++++++++++
 tb/tb_neuron_mac_layer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the dense-layer MAC stage.
// Build option: define MAC_SATURATE_EN to clamp results instead of wrapping them.
package mac_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_t;

    // Container width used to pass any accumulator through fit_word.
    localparam int ACC_MAX_W = 64;

    function automatic int acc_width(input int data_size, input int input_size);
        return 2 * data_size + $clog2(input_size + 1);
    endfunction

    // Drops the fractional bits (floor) and fits the result into data_size bits.
    // The result is sign-extended to ACC_MAX_W; callers keep the low data_size bits.
    function automatic logic signed [ACC_MAX_W-1:0] fit_word(
        input logic signed [ACC_MAX_W-1:0] acc,
        input int                          frac_bits,
        input int                          data_size
    );
        logic signed [ACC_MAX_W-1:0] shifted;
`ifdef MAC_SATURATE_EN
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
`else
        logic signed [ACC_MAX_W-1:0] high_cut;
`endif
        shifted = acc >>> frac_bits;
`ifdef MAC_SATURATE_EN
        hi = (ACC_MAX_W'(1) <<< (data_size - 1)) - ACC_MAX_W'(1);
        lo = ~hi;
        if (shifted > hi) return hi;
        if (shifted < lo) return lo;
        return shifted;
`else
        high_cut = shifted <<< (ACC_MAX_W - data_size);
        return high_cut >>> (ACC_MAX_W - data_size);
`endif
    endfunction

endpackage

// File: rtl/neuron_mac_layer_if.sv
// Stream, control and result signals of the MAC stage; master drives inputs, slave is the stage.
interface neuron_mac_layer_if #(
    parameter int data_size = 16,
    parameter int size      = 3
);
    logic                        start;
    logic [data_size*size-1:0]   bias;
    logic                        in_valid;
    logic                        in_ready;
    logic [data_size-1:0]        in_data;
    logic [data_size*size-1:0]   weight;
    logic                        out_valid;
    logic                        out_ready;
    logic [data_size*size-1:0]   out_data;
    logic                        busy;

    modport master (
        output start, bias, in_valid, in_data, weight, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, bias, in_valid, in_data, weight, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mac_lane.sv
// One neuron: accumulator with clear / load-bias / accumulate controls and a registered,
// rounded result word. Build option MAC_SATURATE_EN selects clamping inside fit_word.
module mac_lane
    import mac_pkg::*;
#(
    parameter int data_size = 16,
    parameter int frac_bits = 8,
    parameter int acc_w     = 34
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_i,
    input  logic                        load_i,
    input  logic                        acc_en_i,
    input  logic                        round_i,
    input  logic signed [data_size-1:0] bias_i,
    input  logic signed [data_size-1:0] in_data_i,
    input  logic signed [data_size-1:0] weight_i,
    output logic        [data_size-1:0] out_data_o
);

    logic signed [acc_w-1:0]       acc_q, acc_d;
    logic        [data_size-1:0]   out_q, out_d;
    logic signed [2*data_size-1:0] product;

    assign product = in_data_i * weight_i;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = acc_w'(bias_i) <<< frac_bits;
        end else if (acc_en_i) begin
            acc_d = acc_q + acc_w'(product);
        end
        if (round_i) begin
            out_d = data_size'(fit_word(ACC_MAX_W'(acc_q), frac_bits, data_size));
        end
    end

    // NOTE: the accumulator and result are reset too, so a mid-inference reset discards
    // partial sums and the output bus reads zero rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out_data_o = out_q;

endmodule

// File: rtl/neuron_mac_layer.sv
// Dense-layer MAC stage: FSM and beat counter driving `size` mac_lane accumulators.
// Build option MAC_SATURATE_EN: results clamp on overflow instead of wrapping.
module neuron_mac_layer
    import mac_pkg::*;
#(
    parameter int data_size  = 16,
    parameter int size       = 3,
    parameter int input_size = 3,
    parameter int frac_bits  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    neuron_mac_layer_if.slave  bus
);

    localparam int ACC_W = acc_width(data_size, input_size);
    localparam int CNT_W = $clog2(input_size + 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      in_ready, out_valid, busy;
    logic                      beat_acc, last_beat, load_bias, clear_acc, do_round;
    logic [data_size*size-1:0] out_data;

    assign beat_acc  = bus.in_valid && in_ready;
    assign last_beat = (count_q == CNT_W'(input_size - 1));
    assign load_bias = (state_q == IDLE) && bus.start;
    assign clear_acc = (state_q == OUT) && bus.out_ready;
    assign do_round  = (state_q == ROUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    count_d = '0;
                end
            end
            ACCUM: begin
                if (beat_acc) begin
                    count_d = count_q + CNT_W'(1);
                    if (last_beat) state_d = ROUND;
                end
            end
            ROUND: state_d = OUT;
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE:    busy      = 1'b0;
            ACCUM:   in_ready  = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // Neuron 0 occupies the most significant slice of every packed bus.
    for (genvar k = 0; k < size; k++) begin : g_lane
        mac_lane #(
            .data_size (data_size),
            .frac_bits (frac_bits),
            .acc_w     (ACC_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear_i    (clear_acc),
            .load_i     (load_bias),
            .acc_en_i   (beat_acc),
            .round_i    (do_round),
            .bias_i     (bus.bias[(size-k)*data_size-1 -: data_size]),
            .in_data_i  (bus.in_data),
            .weight_i   (bus.weight[(size-k)*data_size-1 -: data_size]),
            .out_data_o (out_data[(size-k)*data_size-1 -: data_size])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_data  = out_data;

endmodule

// File: tb/tb_neuron_mac_layer.sv
// Self-checking bench for neuron_mac_layer against a plain-arithmetic dot-product model.
// Honours MAC_SATURATE_EN in the model the same way the build does.
module tb_neuron_mac_layer;

    localparam int DW  = 16;
    localparam int SZ  = 3;
    localparam int NIN = 3;
    localparam int FB  = 8;
    localparam int BW  = DW * SZ;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    neuron_mac_layer_if #(.data_size(DW), .size(SZ)) bus ();

    neuron_mac_layer #(
        .data_size  (DW),
        .size       (SZ),
        .input_size (NIN),
        .frac_bits  (FB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] bias_v [SZ];
    logic signed [DW-1:0] in_v   [NIN];
    logic signed [DW-1:0] w_v    [NIN][SZ];

    // Reference: bias*2^FB + sum(in*w), floored by 2^FB, then wrapped or clamped.
    function automatic logic [DW-1:0] model_lane(input int k);
        longint acc, q, hi, lo;
        acc = longint'(bias_v[k]) * (longint'(1) <<< FB);
        for (int i = 0; i < NIN; i++) acc += longint'(in_v[i]) * longint'(w_v[i][k]);
        q  = acc >>> FB;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -hi - 1;
`ifdef MAC_SATURATE_EN
        if (q > hi) q = hi;
        if (q < lo) q = lo;
`endif
        return DW'(q);
    endfunction

    function automatic logic [BW-1:0] model_vec();
        logic [BW-1:0] v;
        for (int k = 0; k < SZ; k++) v[(SZ-k)*DW-1 -: DW] = model_lane(k);
        return v;
    endfunction

    function automatic logic [BW-1:0] pack_bias();
        logic [BW-1:0] v;
        for (int k = 0; k < SZ; k++) v[(SZ-k)*DW-1 -: DW] = bias_v[k];
        return v;
    endfunction

    function automatic logic [BW-1:0] pack_w(input int i);
        logic [BW-1:0] v;
        for (int k = 0; k < SZ; k++) v[(SZ-k)*DW-1 -: DW] = w_v[i][k];
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_bus();
        return BW'({$urandom(), $urandom()});
    endfunction

    task automatic randomize_vectors();
        for (int k = 0; k < SZ; k++) bias_v[k] = DW'($urandom());
        for (int i = 0; i < NIN; i++) begin
            in_v[i] = DW'($urandom());
            for (int k = 0; k < SZ; k++) w_v[i][k] = DW'($urandom());
        end
    endtask

    task automatic set_basic();
        for (int k = 0; k < SZ; k++) bias_v[k] = '0;
        for (int i = 0; i < NIN; i++) begin
            in_v[i] = DW'((i + 1) * 256);
            for (int k = 0; k < SZ; k++) w_v[i][k] = 16'h0080;
        end
    endtask

    // Runs one inference from IDLE. lat counts cycles from the last beat's cycle to out_valid.
    task automatic drive_inference(input int gap, input int hold, input bit spurious,
                                   output logic [BW-1:0] got, output int lat,
                                   output bit ready_ok, output bit stable_ok, output bit done_ok);
        ready_ok = 1'b1; stable_ok = 1'b1; done_ok = 1'b1; got = '0; lat = 0;
        @(negedge clk);
        bus.bias  = pack_bias();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = spurious;
        if (spurious) bus.bias = rand_bus();
        for (int i = 0; i < NIN; i++) begin
            if (i != 0) begin
                repeat (gap) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = DW'($urandom());
                    if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = in_v[i];
            bus.weight   = pack_w(i);
            if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (bus.out_valid !== 1'b1) begin
            done_ok = 1'b0;
            bus.start = 1'b0;
            return;
        end
        got = bus.out_data;
        repeat (hold) begin
            @(negedge clk);
            if (bus.out_data !== got || bus.out_valid !== 1'b1) stable_ok = 1'b0;
        end
        bus.out_ready = 1'b1;
        bus.start     = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) done_ok = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    endtask

    task automatic test_basic();
        logic [BW-1:0] got; int lat; bit r_ok, s_ok, d_ok;
        set_basic();
        drive_inference(0, 0, 1'b0, got, lat, r_ok, s_ok, d_ok);
        checks++;
        if (got !== {SZ{16'h0300}}) begin errors++; $display("FAIL basic_data got %h want %h", got, {SZ{16'h0300}}); end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", lat); end
        checks++;
        if (!(r_ok && d_ok)) begin errors++; $display("FAIL basic_handshake ready_ok %b done_ok %b want 1 1", r_ok, d_ok); end
    endtask

    task automatic test_signed();
        logic [BW-1:0] got, exp; int lat; bit r_ok, s_ok, d_ok;
        randomize_vectors();
        bias_v[0] = 16'h0080;
        for (int i = 0; i < NIN; i++) begin
            in_v[i]    = 16'hFF00;
            w_v[i][0]  = 16'h0200;
        end
        exp = model_vec();
        drive_inference(0, 1, 1'b0, got, lat, r_ok, s_ok, d_ok);
        checks++;
        if (got[BW-1 -: DW] !== 16'hFA80) begin errors++; $display("FAIL signed_lane0 got %h want fa80", got[BW-1 -: DW]); end
        checks++;
        if (got !== exp || !d_ok) begin errors++; $display("FAIL signed_all got %h want %h", got, exp); end
    endtask

    task automatic test_overflow();
        logic [BW-1:0] got; int lat; bit r_ok, s_ok, d_ok;
        logic [DW-1:0] exp_pos, exp_neg;
`ifdef MAC_SATURATE_EN
        exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
        exp_pos = 16'hFD00; exp_neg = 16'h0180;
`endif
        for (int k = 0; k < SZ; k++) bias_v[k] = '0;
        for (int i = 0; i < NIN; i++) begin
            in_v[i] = 16'h7FFF;
            for (int k = 0; k < SZ; k++) w_v[i][k] = 16'h7FFF;
        end
        drive_inference(0, 0, 1'b0, got, lat, r_ok, s_ok, d_ok);
        checks++;
        if (got !== {SZ{exp_pos}}) begin errors++; $display("FAIL overflow_pos got %h want %h", got, {SZ{exp_pos}}); end
        for (int i = 0; i < NIN; i++) in_v[i] = 16'h8000;
        drive_inference(0, 0, 1'b0, got, lat, r_ok, s_ok, d_ok);
        checks++;
        if (got !== {SZ{exp_neg}}) begin errors++; $display("FAIL overflow_neg got %h want %h", got, {SZ{exp_neg}}); end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] got, exp; int lat; bit r_ok, s_ok, d_ok;
        randomize_vectors();
        exp = model_vec();
        drive_inference(2, 5, 1'b0, got, lat, r_ok, s_ok, d_ok);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL bp_data got %h want %h", got, exp); end
        checks++;
        if (!r_ok) begin errors++; $display("FAIL bp_in_ready got low want high in ACCUM"); end
        checks++;
        if (!s_ok) begin errors++; $display("FAIL bp_stable got changing want held"); end
        checks++;
        if (!d_ok) begin errors++; $display("FAIL bp_return got busy/out_valid high want idle"); end
    endtask

    task automatic test_spurious_start();
        logic [BW-1:0] got, exp; int lat; bit r_ok, s_ok, d_ok;
        randomize_vectors();
        exp = model_vec();
        drive_inference(1, 3, 1'b1, got, lat, r_ok, s_ok, d_ok);
        checks++;
        if (got !== exp || !d_ok) begin errors++; $display("FAIL spurious_ignored got %h want %h", got, exp); end
        checks++;
        @(negedge clk);
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL spurious_not_queued got busy %b want 0", bus.busy); end
        for (int k = 0; k < SZ; k++) bias_v[k] = DW'($urandom());
        exp = model_vec();
        drive_inference(0, 0, 1'b0, got, lat, r_ok, s_ok, d_ok);
        checks++;
        if (got !== exp || !d_ok) begin errors++; $display("FAIL spurious_next got %h want %h", got, exp); end
    endtask

    task automatic test_async_reset();
        logic [BW-1:0] got; int lat; bit r_ok, s_ok, d_ok;
        set_basic();
        @(negedge clk);
        bus.bias  = pack_bias();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = in_v[i];
            bus.weight   = pack_w(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b000 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL async_reset got v%b r%b b%b d%h want all 0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_inference(0, 0, 1'b0, got, lat, r_ok, s_ok, d_ok);
        checks++;
        if (got !== {SZ{16'h0300}} || lat !== 2) begin
            errors++;
            $display("FAIL reset_recover got %h lat %0d want %h lat 2", got, lat, {SZ{16'h0300}});
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] got, exp; int lat; bit r_ok, s_ok, d_ok;
        for (int n = 0; n < 20; n++) begin
            randomize_vectors();
            exp = model_vec();
            drive_inference(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            got, lat, r_ok, s_ok, d_ok);
            checks++;
            if (got !== exp || !(r_ok && s_ok && d_ok) || lat !== 2) begin
                errors++;
                $display("FAIL random_%0d got %h lat %0d want %h lat 2", n, got, lat, exp);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.weight    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_signed();
        test_overflow();
        test_backpressure();
        test_spurious_start();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
